// File: rtl/act_buf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : act_buf_pkg
// Purpose  : Shared types and helpers for the ping-pong activation buffer.
//            Defines the per-bank lifecycle state and small helpers for
//            classifying bank states and locating lanes inside a packed
//            activation vector.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package act_buf_pkg;

  // Lifecycle of one bank: filled by the writer, handed over, drained by the
  // reader, then recycled.
  typedef enum logic [1:0] {
    BANK_FREE  = 2'd0,
    BANK_FILL  = 2'd1,
    BANK_READY = 2'd2,
    BANK_DRAIN = 2'd3
  } bank_state_e;

  // A bank accepts writes until it has been closed.
  function automatic logic bank_writable(input bank_state_e s);
    return (s == BANK_FREE) || (s == BANK_FILL);
  endfunction

  // A bank presents data once closed and until its last vector is consumed.
  function automatic logic bank_readable(input bank_state_e s);
    return (s == BANK_READY) || (s == BANK_DRAIN);
  endfunction

  // Bit offset of a lane inside a packed vector (lane 0 in the LSBs).
  // Pack:   vec[lane_offset(l, w) +: w] = elem;
  // Unpack: elem = vec[lane_offset(l, w) +: w];
  function automatic int lane_offset(input int lane, input int data_w);
    return lane * data_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/act_pingpong_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : act_pingpong_buffer_if
// Purpose  : Write and read handshake bundle of the ping-pong activation
//            buffer.
// Signals  : wr_data/wr_valid/wr_last -> buffer, wr_ready <- buffer
//            rd_data/rd_valid/rd_last <- buffer, rd_ready/rd_hold -> buffer
// Modports : master - the side driving writes and consuming reads
//            slave  - the buffer itself
// Revision : 1.0 - initial release
// ============================================================================
interface act_pingpong_buffer_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
);

  logic [LANES*DATA_W-1:0] wr_data;
  logic                    wr_valid;
  logic                    wr_last;
  logic                    wr_ready;
  logic [LANES*DATA_W-1:0] rd_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic                    rd_last;
  logic                    rd_hold;

  modport master (
    output wr_data, wr_valid, wr_last, rd_ready, rd_hold,
    input  wr_ready, rd_data, rd_valid, rd_last
  );

  modport slave (
    input  wr_data, wr_valid, wr_last, rd_ready, rd_hold,
    output wr_ready, rd_data, rd_valid, rd_last
  );

endinterface
`default_nettype wire

// File: rtl/act_buf_bank.sv
`default_nettype none
// ============================================================================
// Module   : act_buf_bank
// Purpose  : One bank of the ping-pong activation buffer: DEPTH vectors of
//            storage, write/read pointers, a tile count and the bank FSM
//            FREE -> FILL -> READY -> DRAIN -> FREE.
// Ports    : clk, rst_n          clock, async active-low reset
//            clr                 synchronous clear back to FREE
//            wr_en/wr_close      store wr_data; close the tile on this write
//            rd_en/rd_rewind     consume one vector; on the last vector keep
//                                the tile and rewind instead of freeing
//            state               current bank state
//            rd_valid/rd_last    read-side status, rd_data zero when invalid
//            wr_level/rd_level   vectors written / vectors left to read
// Revision : 1.0 - initial release
// ============================================================================
module act_buf_bank
  import act_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    wr_en,
  input  logic                    wr_close,
  input  logic [LANES*DATA_W-1:0] wr_data,
  input  logic                    rd_en,
  input  logic                    rd_rewind,
  output bank_state_e             state,
  output logic                    rd_valid,
  output logic                    rd_last,
  output logic [LANES*DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]        wr_level,
  output logic [CNT_W-1:0]        rd_level
);

  localparam int               c_vec_w     = LANES * DATA_W;
  localparam int               c_addr_w    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_last_slot = CNT_W'(DEPTH - 1);

  bank_state_e      state_q,  state_d;
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic [c_vec_w-1:0] mem_q [DEPTH];
  logic [c_vec_w-1:0] mem_d [DEPTH];

  logic rd_at_last;
  logic wr_at_full;

  assign rd_at_last = (rd_ptr_q == (count_q - c_one));
  assign wr_at_full = (wr_ptr_q == c_last_slot);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= BANK_FREE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: it is only observed while the bank is readable,
  // and every readable slot has been written first.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // --------------------------------------------------------------------------
  // Next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (clr) begin
      state_d  = BANK_FREE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      case (state_q)
        BANK_FREE, BANK_FILL: begin
          if (wr_en) begin
            mem_d[wr_ptr_q[c_addr_w-1:0]] = wr_data;
            wr_ptr_d = wr_ptr_q + c_one;
            // The DEPTH-th vector closes the tile even without wr_last.
            if (wr_close || wr_at_full) begin
              state_d = BANK_READY;
              count_d = wr_ptr_q + c_one;
            end else begin
              state_d = BANK_FILL;
            end
          end
        end
        BANK_READY, BANK_DRAIN: begin
          if (rd_en) begin
            if (rd_at_last) begin
              rd_ptr_d = '0;
              if (rd_rewind) begin
                // Tile stays resident for replay; count is kept.
                state_d = BANK_READY;
              end else begin
                state_d  = BANK_FREE;
                wr_ptr_d = '0;
                count_d  = '0;
              end
            end else begin
              rd_ptr_d = rd_ptr_q + c_one;
              state_d  = BANK_DRAIN;
            end
          end
        end
        default: state_d = BANK_FREE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state    = state_q;
    rd_valid = bank_readable(state_q);
    rd_last  = rd_valid && rd_at_last;
    rd_data  = rd_valid ? mem_q[rd_ptr_q[c_addr_w-1:0]] : '0;
    wr_level = wr_ptr_q;
    rd_level = count_q - rd_ptr_q;
  end

endmodule
`default_nettype wire

// File: rtl/act_pingpong_buffer.sv
`default_nettype none
// ============================================================================
// Module   : act_pingpong_buffer
// Purpose  : Two-bank ping-pong activation buffer feeding the systolic array
//            input setup. The writer fills bank wr_sel while the reader
//            drains bank ~wr_sel; banks swap once the write bank is closed
//            and the read bank is free. rd_hold on the last read keeps the
//            tile for replay.
// Ports    : clk, rst_n   clock, async active-low reset
//            flush        synchronous clear of both banks
//            bus          write/read handshakes (slave modport)
//            wr_level     vectors in the current write bank
//            rd_level     vectors remaining in the current read bank
//            wr_sel       index of the write bank; read bank is ~wr_sel
// Revision : 1.0 - initial release
// ============================================================================
module act_pingpong_buffer
  import act_buf_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  act_pingpong_buffer_if.slave   bus,
  output logic [CNT_W-1:0]       wr_level,
  output logic [CNT_W-1:0]       rd_level,
  output logic                   wr_sel
);

  localparam int c_vec_w = LANES * DATA_W;

  logic wr_sel_q, wr_sel_d;
  logic rd_sel;
  logic wr_ready;
  logic rd_valid;
  logic wr_fire;
  logic rd_fire;
  logic swap;

  bank_state_e        bank_state    [2];
  logic               bank_wr_en    [2];
  logic               bank_rd_en    [2];
  logic               bank_rd_valid [2];
  logic               bank_rd_last  [2];
  logic [c_vec_w-1:0] bank_rd_data  [2];
  logic [CNT_W-1:0]   bank_wr_level [2];
  logic [CNT_W-1:0]   bank_rd_level [2];

  assign rd_sel   = ~wr_sel_q;
  assign wr_ready = bank_writable(bank_state[wr_sel_q]);
  assign rd_valid = bank_rd_valid[rd_sel];
  assign wr_fire  = bus.wr_valid && wr_ready;
  assign rd_fire  = rd_valid && bus.rd_ready;

  // A swap needs the write bank READY, so it can never coincide with a write.
  // A held tile leaves the read bank READY, which blocks the swap.
  assign swap = (bank_state[wr_sel_q] == BANK_READY) &&
                (bank_state[rd_sel]   == BANK_FREE);

  // --------------------------------------------------------------------------
  // Bank select register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel_q <= 1'b0;
    end else begin
      wr_sel_q <= wr_sel_d;
    end
  end

  always_comb begin
    wr_sel_d = wr_sel_q;
    if (flush) begin
      wr_sel_d = 1'b0;
    end else if (swap) begin
      wr_sel_d = ~wr_sel_q;
    end
  end

  // --------------------------------------------------------------------------
  // Banks
  // --------------------------------------------------------------------------
  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_wr_en[b] = wr_fire && (wr_sel_q == 1'(b));
    assign bank_rd_en[b] = rd_fire && (rd_sel   == 1'(b));

    act_buf_bank #(
      .DATA_W (DATA_W),
      .LANES  (LANES),
      .DEPTH  (DEPTH),
      .CNT_W  (CNT_W)
    ) u_bank (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (flush),
      .wr_en     (bank_wr_en[b]),
      .wr_close  (bus.wr_last),
      .wr_data   (bus.wr_data),
      .rd_en     (bank_rd_en[b]),
      .rd_rewind (bus.rd_hold),
      .state     (bank_state[b]),
      .rd_valid  (bank_rd_valid[b]),
      .rd_last   (bank_rd_last[b]),
      .rd_data   (bank_rd_data[b]),
      .wr_level  (bank_wr_level[b]),
      .rd_level  (bank_rd_level[b])
    );
  end

  // --------------------------------------------------------------------------
  // Output muxing
  // --------------------------------------------------------------------------
  always_comb begin
    bus.wr_ready = wr_ready;
    bus.rd_valid = rd_valid;
    bus.rd_last  = bank_rd_last[rd_sel];
    bus.rd_data  = bank_rd_data[rd_sel];
    wr_level     = bank_wr_level[wr_sel_q];
    rd_level     = bank_rd_level[rd_sel];
    wr_sel       = wr_sel_q;
  end

endmodule
`default_nettype wire
